// File: rtl/demux_1to8_glr.sv
// Registered 1-to-8 demultiplexer: D is routed to the output selected by S,
// every other output is cleared, all with one cycle of latency.
module demux_1to8_glr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7
);

  logic [WIDTH-1:0] lane_s [8];
  logic [WIDTH-1:0] lane_r [8];

  // Decode S into next lane values: only the selected lane carries D.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      lane_s[n] = {WIDTH{1'b0}};
    end
    case (S)
      3'd0:    lane_s[0] = D;
      3'd1:    lane_s[1] = D;
      3'd2:    lane_s[2] = D;
      3'd3:    lane_s[3] = D;
      3'd4:    lane_s[4] = D;
      3'd5:    lane_s[5] = D;
      3'd6:    lane_s[6] = D;
      3'd7:    lane_s[7] = D;
      default: lane_s[0] = {WIDTH{1'b0}};
    endcase
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) begin
        lane_r[n] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        lane_r[n] <= lane_s[n];
      end
    end
  end

  assign Y0 = lane_r[0];
  assign Y1 = lane_r[1];
  assign Y2 = lane_r[2];
  assign Y3 = lane_r[3];
  assign Y4 = lane_r[4];
  assign Y5 = lane_r[5];
  assign Y6 = lane_r[6];
  assign Y7 = lane_r[7];

endmodule

// File: tb/tb_demux_1to8_glr.sv
// Self-checking bench for demux_1to8_glr: directed steps plus random traffic,
// using a 1-bit and a 4-bit instance driven from the same clock and reset.
module tb_demux_1to8_glr;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic [2:0] s1;
  logic [3:0] d4;
  logic [2:0] s4;

  logic       y1_0, y1_1, y1_2, y1_3, y1_4, y1_5, y1_6, y1_7;
  logic [3:0] y4_0, y4_1, y4_2, y4_3, y4_4, y4_5, y4_6, y4_7;

  logic [7:0]  bus1;
  logic [31:0] bus4;

  int vectors;
  int miscompares;

  demux_1to8_glr #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .D(d1), .S(s1),
    .Y0(y1_0), .Y1(y1_1), .Y2(y1_2), .Y3(y1_3),
    .Y4(y1_4), .Y5(y1_5), .Y6(y1_6), .Y7(y1_7)
  );

  demux_1to8_glr #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .D(d4), .S(s4),
    .Y0(y4_0), .Y1(y4_1), .Y2(y4_2), .Y3(y4_3),
    .Y4(y4_4), .Y5(y4_5), .Y6(y4_6), .Y7(y4_7)
  );

  assign bus1 = {y1_7, y1_6, y1_5, y1_4, y1_3, y1_2, y1_1, y1_0};
  assign bus4 = {y4_7, y4_6, y4_5, y4_4, y4_3, y4_2, y4_1, y4_0};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: the selected lane (width w, index sel) holds data, the rest are zero.
  function automatic logic [31:0] model(input int w, input int sel, input logic [31:0] data);
    logic [31:0] v;
    v = data;
    return v << (w * sel);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] e1;
  logic [31:0] e4;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    d1 = 1'b1;
    s1 = 3'b101;
    d4 = 4'b1111;
    s4 = 3'b101;

    // Reset held low while clocking: everything stays zero.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_hold_w1", {24'd0, bus1}, 32'd0);
      chk("reset_hold_w4", bus4, 32'd0);
    end

    // Releasing reset mid-cycle must not change outputs.
    #2 rst_n = 1'b1;
    #1 chk("reset_release", {24'd0, bus1}, 32'd0);

    // First edge after release loads S=101.
    tick();
    chk("first_load_w1", {24'd0, bus1}, model(1, 5, 32'd1));
    chk("first_load_w4", bus4, model(4, 5, 32'hF));

    // Select sweep with D=1.
    d1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      s1 = 3'(n);
      tick();
      chk($sformatf("sweep_s%0d", n), {24'd0, bus1}, model(1, n, 32'd1));
    end
    chk("sweep_s3_literal", {24'd0, 8'b0000_1000}, model(1, 3, 32'd1));

    // Zero data for each select code.
    d1 = 1'b0;
    d4 = 4'b0000;
    for (int n = 0; n < 8; n++) begin
      s1 = 3'(n);
      s4 = 3'(7 - n);
      tick();
      chk($sformatf("zero_w1_s%0d", n), {24'd0, bus1}, 32'd0);
      chk($sformatf("zero_w4_s%0d", 7 - n), bus4, 32'd0);
    end

    // Mid-cycle select change only takes effect at the next edge.
    d1 = 1'b1;
    s1 = 3'b010;
    tick();
    chk("lat_before", {24'd0, bus1}, 32'h04);
    #3 s1 = 3'b110;
    #2 chk("lat_midcycle", {24'd0, bus1}, 32'h04);
    tick();
    chk("lat_after", {24'd0, bus1}, 32'h40);

    // Asynchronous reset in mid-operation.
    s1 = 3'b100;
    d4 = 4'b0110;
    s4 = 3'b100;
    tick();
    chk("async_pre_w1", {24'd0, bus1}, 32'h10);
    chk("async_pre_w4", bus4, model(4, 4, 32'h6));
    #3 rst_n = 1'b0;
    #1 chk("async_clear_w1", {24'd0, bus1}, 32'd0);
    chk("async_clear_w4", bus4, 32'd0);
    #3 rst_n = 1'b1;
    #1 chk("async_release", {24'd0, bus1}, 32'd0);
    tick();
    chk("async_reload_w1", {24'd0, bus1}, 32'h10);
    chk("async_reload_w4", bus4, model(4, 4, 32'h6));

    // Wide data to the top lane.
    d4 = 4'b1010;
    s4 = 3'b111;
    tick();
    chk("wide_s7", bus4, 32'hA000_0000);

    // Random traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      d1 = 1'($urandom_range(0, 1));
      s1 = 3'($urandom_range(0, 7));
      d4 = 4'($urandom_range(0, 15));
      s4 = 3'($urandom_range(0, 7));
      e1 = model(1, int'(s1), {31'd0, d1});
      e4 = model(4, int'(s4), {28'd0, d4});
      tick();
      // Perturb inputs between edges; outputs must follow the sampled values only.
      s1 = 3'($urandom_range(0, 7));
      s4 = 3'($urandom_range(0, 7));
      #2;
      chk("rand_w1", {24'd0, bus1}, e1);
      chk("rand_w4", bus4, e4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
